// File: rtl/accum_mult_iter_if.sv
// Operand/result handshake bundle for the iterative accumulate multiplier.
interface accum_mult_iter_if #(
  parameter int unsigned BITS  = 384,
  parameter int unsigned TAG_W = 8
);
  logic                 i_val;
  logic                 o_rdy;
  logic [BITS-1:0]      i_dat_a;
  logic [BITS-1:0]      i_dat_b;
  logic                 i_sqr;
  logic [TAG_W-1:0]     i_tag;
  logic                 o_val;
  logic                 i_rdy;
  logic [2*BITS-1:0]    o_dat;
  logic [TAG_W-1:0]     o_tag;

  // Upstream/downstream side: drives operands, accepts results.
  modport master (
    output i_val, i_dat_a, i_dat_b, i_sqr, i_tag, i_rdy,
    input  o_rdy, o_val, o_dat, o_tag
  );

  // Multiplier side.
  modport slave (
    input  i_val, i_dat_a, i_dat_b, i_sqr, i_tag, i_rdy,
    output o_rdy, o_val, o_dat, o_tag
  );
endinterface

// File: rtl/accum_mult_iter.sv
// Iterative DSP-folded unsigned multiplier: B is consumed ROWS_PER_CYC DSP
// rows per pass, partial products are accumulated into a 2*BITS result.
// Product path is two registered stages (DSP sub-products, then row/column
// combine), so the last pass drains through FLUSH before the result loads.
module accum_mult_iter #(
  parameter int unsigned BITS         = 384,
  parameter int unsigned A_DSP_W      = 26,
  parameter int unsigned B_DSP_W      = 17,
  parameter int unsigned ROWS_PER_CYC = 4,
  parameter int unsigned TAG_W        = 8
) (
  input  logic                i_clk,
  input  logic                i_rst,
  accum_mult_iter_if.slave    bus
);

  localparam int unsigned NUM_COL  = (BITS + A_DSP_W - 1) / A_DSP_W;
  localparam int unsigned NUM_ROW  = (BITS + B_DSP_W - 1) / B_DSP_W;
  localparam int unsigned CHUNK_W  = ROWS_PER_CYC * B_DSP_W;
  localparam int unsigned NUM_PASS = (NUM_ROW + ROWS_PER_CYC - 1) / ROWS_PER_CYC;
  localparam int unsigned A_PAD_W  = NUM_COL * A_DSP_W;
  localparam int unsigned B_PAD_W  = NUM_PASS * CHUNK_W;
  localparam int unsigned SUB_W    = A_DSP_W + B_DSP_W;
  localparam int unsigned NUM_SUB  = NUM_COL * ROWS_PER_CYC;
  localparam int unsigned PROD_W   = A_PAD_W + CHUNK_W;
  localparam int unsigned ACC_W    = 2 * BITS + CHUNK_W;
  localparam int unsigned K_W      = $clog2(NUM_PASS + 1);
  localparam logic [K_W-1:0] K_LAST = K_W'(NUM_PASS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic                accept_c;
  logic                load_c;

  logic [A_PAD_W-1:0]  a_q;
  logic [B_PAD_W-1:0]  b_q;
  logic [TAG_W-1:0]    tag_q;
  logic [K_W-1:0]      k_q;

  logic [SUB_W-1:0]    sub_q [NUM_SUB];
  logic                m_vld_q;
  logic [K_W-1:0]      m_k_q;

  logic [PROD_W-1:0]   prod_c;
  logic [PROD_W-1:0]   p_q;
  logic                p_vld_q;
  logic [K_W-1:0]      p_k_q;

  logic [ACC_W-1:0]    acc_q;
  logic [ACC_W-1:0]    acc_sum_c;

  logic                o_val_q;
  logic [2*BITS-1:0]   o_dat_q;
  logic [TAG_W-1:0]    o_tag_q;

  // Ready only in IDLE and never while reset is held.
  assign bus.o_rdy = (state_q == S_IDLE) && !i_rst;
  assign bus.o_val = o_val_q;
  assign bus.o_dat = o_dat_q;
  assign bus.o_tag = o_tag_q;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and control strobes.
  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    load_c   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.i_val) begin
          accept_c = 1'b1;
          state_d  = S_MUL;
        end
      end
      S_MUL: begin
        if (k_q == K_LAST) begin
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (p_vld_q && (p_k_q == K_LAST)) begin
          load_c  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.i_rdy) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Operand capture; squaring mode copies A into B at acceptance only.
  always_ff @(posedge i_clk) begin
    if (accept_c) begin
      a_q   <= A_PAD_W'(bus.i_dat_a);
      b_q   <= B_PAD_W'(bus.i_sqr ? bus.i_dat_a : bus.i_dat_b);
      tag_q <= bus.i_tag;
    end
  end

  // Pass counter: selects which CHUNK_W slice of B is issued this cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      k_q <= '0;
    end else if (accept_c) begin
      k_q <= '0;
    end else if (state_q == S_MUL) begin
      k_q <= k_q + K_W'(1);
    end
  end

  // DSP sub-products for the current pass: NUM_COL A slices x ROWS_PER_CYC B rows.
  always_ff @(posedge i_clk) begin
    if (state_q == S_MUL) begin
      for (int c = 0; c < NUM_COL; c++) begin
        for (int r = 0; r < ROWS_PER_CYC; r++) begin
          sub_q[c*ROWS_PER_CYC + r] <=
            SUB_W'(a_q[c*A_DSP_W +: A_DSP_W]) *
            SUB_W'(b_q[k_q*CHUNK_W + r*B_DSP_W +: B_DSP_W]);
        end
      end
    end
  end

  // Valid/pass-index pipeline alongside the two product stages.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      m_vld_q <= 1'b0;
      m_k_q   <= '0;
      p_vld_q <= 1'b0;
      p_k_q   <= '0;
    end else begin
      m_vld_q <= (state_q == S_MUL);
      m_k_q   <= k_q;
      p_vld_q <= m_vld_q;
      p_k_q   <= m_k_q;
    end
  end

  // Combine sub-products into the pass product P_k = A * B_chunk_k.
  always_comb begin
    prod_c = '0;
    for (int c = 0; c < NUM_COL; c++) begin
      for (int r = 0; r < ROWS_PER_CYC; r++) begin
        prod_c = prod_c +
          (PROD_W'(sub_q[c*ROWS_PER_CYC + r]) << (c*A_DSP_W + r*B_DSP_W));
      end
    end
  end

  // Registered pass product.
  always_ff @(posedge i_clk) begin
    p_q <= prod_c;
  end

  // Accumulator plus the registered pass product placed at its chunk offset.
  always_comb begin
    acc_sum_c = acc_q + (ACC_W'(p_q) << (p_k_q * CHUNK_W));
  end

  // Accumulator update.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      acc_q <= '0;
    end else if (accept_c) begin
      acc_q <= '0;
    end else if (p_vld_q) begin
      acc_q <= acc_sum_c;
    end
  end

  // Result registers: loaded once at the end of FLUSH, held through DONE.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_val_q <= 1'b0;
      o_dat_q <= '0;
      o_tag_q <= '0;
    end else begin
      o_val_q <= (state_d == S_DONE);
      if (load_c) begin
        o_dat_q <= acc_sum_c[2*BITS-1:0];
        o_tag_q <= tag_q;
      end
    end
  end

endmodule

// File: tb/tb_accum_mult_iter.sv
// Self-checking bench for accum_mult_iter: directed cases plus a randomized
// run scored against a plain-arithmetic product model.
module tb_accum_mult_iter;

  localparam int unsigned BITS  = 384;
  localparam int unsigned TAG_W = 8;
  localparam int unsigned LAT   = 8;
  localparam int unsigned II    = 9;
  localparam int unsigned N_RND = 1000;

  typedef struct {
    logic [BITS-1:0]   a;
    logic [BITS-1:0]   b;
    logic              sqr;
    logic [TAG_W-1:0]  tag;
    int                cyc;
  } acc_t;

  typedef struct {
    logic [2*BITS-1:0] dat;
    logic [TAG_W-1:0]  tag;
    int                cyc;
  } out_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  logic oval_prev = 1'b0;

  acc_t acc_q[$];
  out_t out_q[$];
  int   rise_q[$];

  accum_mult_iter_if #(.BITS(BITS), .TAG_W(TAG_W)) bus ();

  accum_mult_iter #(
    .BITS(BITS), .A_DSP_W(26), .B_DSP_W(17), .ROWS_PER_CYC(4), .TAG_W(TAG_W)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record accepts, result handshakes and o_val rises (edge index of the event).
  always @(negedge clk) begin
    acc_t ea;
    out_t eo;
    if (!rst) begin
      if (bus.i_val && bus.o_rdy) begin
        ea.a = bus.i_dat_a; ea.b = bus.i_dat_b; ea.sqr = bus.i_sqr;
        ea.tag = bus.i_tag; ea.cyc = cyc + 1;
        acc_q.push_back(ea);
      end
      if (bus.o_val && bus.i_rdy) begin
        eo.dat = bus.o_dat; eo.tag = bus.o_tag; eo.cyc = cyc + 1;
        out_q.push_back(eo);
      end
      if (bus.o_val && !oval_prev) rise_q.push_back(cyc);
    end
    oval_prev <= bus.o_val;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [2*BITS-1:0] obs, input logic [2*BITS-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2*BITS-1:0] ref_mul(input logic [BITS-1:0] a, input logic [BITS-1:0] b,
                                                 input logic sqr);
    logic [2*BITS-1:0] x;
    logic [2*BITS-1:0] y;
    x = (2*BITS)'(a);
    y = sqr ? (2*BITS)'(a) : (2*BITS)'(b);
    return x * y;
  endfunction

  function automatic logic [BITS-1:0] rnd_op();
    logic [BITS-1:0] v;
    int sel;
    for (int i = 0; i < BITS/32; i++) v[i*32 +: 32] = $urandom;
    sel = $urandom_range(7);
    case (sel)
      0: v = '0;
      1: v = '1;
      2: v = BITS'(1) << $urandom_range(BITS-1);
      3: v = BITS'($urandom);
      default: ;
    endcase
    return v;
  endfunction

  // Present one operation and hold i_val until it is accepted (called after posedge+#1).
  task automatic send(input logic [BITS-1:0] a, input logic [BITS-1:0] b,
                      input logic sqr, input logic [TAG_W-1:0] tag);
    int n0;
    n0 = acc_q.size();
    bus.i_dat_a = a; bus.i_dat_b = b; bus.i_sqr = sqr; bus.i_tag = tag;
    bus.i_val = 1'b1;
    for (int i = 0; i < 40 && acc_q.size() == n0; i++) begin
      @(posedge clk); #1;
    end
    bus.i_val = 1'b0;
    chk("accept", (2*BITS)'(acc_q.size()), (2*BITS)'(n0 + 1));
  endtask

  // Wait (bounded) for o_val; returns at the negedge where it is first seen.
  task automatic wait_oval();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.o_val) break;
    end
    chk("oval_seen", (2*BITS)'(bus.o_val), (2*BITS)'(1));
  endtask

  initial begin
    logic [BITS-1:0]   a;
    logic [BITS-1:0]   b;
    logic [2*BITS-1:0] e;
    int nr, na, no, iter;

    bus.i_val = 1'b0; bus.i_dat_a = '0; bus.i_dat_b = '0; bus.i_sqr = 1'b0;
    bus.i_tag = '0; bus.i_rdy = 1'b1;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_o_rdy", (2*BITS)'(bus.o_rdy), '0);
    chk("rst_o_val", (2*BITS)'(bus.o_val), '0);
    chk("rst_o_dat", bus.o_dat, '0);
    chk("rst_o_tag", (2*BITS)'(bus.o_tag), '0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rel_o_rdy", (2*BITS)'(bus.o_rdy), (2*BITS)'(1));

    // 3*5 with latency and single-cycle o_val.
    @(posedge clk); #1;
    send(BITS'(3), BITS'(5), 1'b0, 8'h11);
    wait_oval();
    chk("t1_lat", (2*BITS)'(cyc - acc_q[acc_q.size()-1].cyc), (2*BITS)'(LAT));
    chk("t1_dat", bus.o_dat, (2*BITS)'(15));
    chk("t1_tag", (2*BITS)'(bus.o_tag), (2*BITS)'(8'h11));
    @(negedge clk);
    chk("t1_oval_drop", (2*BITS)'(bus.o_val), '0);
    chk("t1_rdy_back", (2*BITS)'(bus.o_rdy), (2*BITS)'(1));

    // All-ones operands: carries through every chunk.
    @(posedge clk); #1;
    a = '1;
    send(a, a, 1'b0, 8'h22);
    wait_oval();
    e = '0;
    e = e - ((2*BITS)'(1) << (BITS + 1)) + (2*BITS)'(1);
    chk("t2_dat", bus.o_dat, e);
    chk("t2_tag", (2*BITS)'(bus.o_tag), (2*BITS)'(8'h22));

    // Squaring ignores B.
    @(posedge clk); #1;
    send(BITS'(32'hDEADBEEF), rnd_op(), 1'b1, 8'h33);
    wait_oval();
    chk("t3_sqr", bus.o_dat, (2*BITS)'(64'hC1B1CD12216DA321));

    // Backpressure: result held, busy pulses ignored, single handshake.
    @(posedge clk); #1;
    bus.i_rdy = 1'b0;
    a = rnd_op(); b = rnd_op();
    send(a, b, 1'b0, 8'h5A);
    wait_oval();
    e = ref_mul(a, b, 1'b0);
    na = acc_q.size();
    no = out_q.size();
    for (int i = 0; i < 20; i++) begin
      chk("bp_dat", bus.o_dat, e);
      chk("bp_tag", (2*BITS)'(bus.o_tag), (2*BITS)'(8'h5A));
      chk("bp_oval", (2*BITS)'(bus.o_val), (2*BITS)'(1));
      chk("bp_ordy", (2*BITS)'(bus.o_rdy), '0);
      @(posedge clk); #1;
      bus.i_val = 1'($urandom_range(1));
      bus.i_dat_a = rnd_op(); bus.i_dat_b = rnd_op(); bus.i_tag = 8'($urandom);
      @(negedge clk);
    end
    @(posedge clk); #1;
    bus.i_val = 1'b0;
    bus.i_rdy = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    chk("bp_one_hs", (2*BITS)'(out_q.size()), (2*BITS)'(no + 1));
    chk("bp_no_acc", (2*BITS)'(acc_q.size()), (2*BITS)'(na));
    chk("bp_hs_dat", out_q[out_q.size()-1].dat, e);
    @(negedge clk);
    chk("bp_oval_drop", (2*BITS)'(bus.o_val), '0);
    chk("bp_rdy_back", (2*BITS)'(bus.o_rdy), (2*BITS)'(1));

    // Reset during the third MUL cycle aborts the operation.
    @(posedge clk); #1;
    nr = rise_q.size();
    send(rnd_op(), rnd_op(), 1'b0, 8'h44);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("ab_rdy_rst", (2*BITS)'(bus.o_rdy), '0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("ab_rdy_rel", (2*BITS)'(bus.o_rdy), (2*BITS)'(1));
    repeat (15) @(negedge clk);
    chk("ab_no_oval", (2*BITS)'(bus.o_val), '0);
    @(posedge clk); #1;
    chk("ab_no_rise", (2*BITS)'(rise_q.size()), (2*BITS)'(nr));
    send(BITS'(7), BITS'(9), 1'b0, 8'h55);
    wait_oval();
    chk("ab_next_dat", bus.o_dat, (2*BITS)'(63));
    chk("ab_next_tag", (2*BITS)'(bus.o_tag), (2*BITS)'(8'h55));

    // Randomized traffic with random i_val/i_rdy and mixed squaring.
    @(posedge clk); #1;
    @(posedge clk); #1;
    acc_q.delete(); out_q.delete(); rise_q.delete();
    iter = 0;
    while ((acc_q.size() < N_RND || out_q.size() < N_RND) && iter < 30000) begin
      iter++;
      if (acc_q.size() < N_RND) begin
        bus.i_val   = ($urandom_range(3) != 0);
        bus.i_dat_a = rnd_op();
        bus.i_dat_b = rnd_op();
        bus.i_sqr   = 1'($urandom_range(1));
        bus.i_tag   = 8'($urandom);
      end else begin
        bus.i_val = 1'b0;
      end
      bus.i_rdy = ($urandom_range(3) != 0) || (acc_q.size() >= N_RND);
      @(posedge clk); #1;
    end
    bus.i_val = 1'b0;
    bus.i_rdy = 1'b1;
    chk("rnd_acc_cnt", (2*BITS)'(acc_q.size()), (2*BITS)'(N_RND));
    chk("rnd_out_cnt", (2*BITS)'(out_q.size()), (2*BITS)'(N_RND));
    chk("rnd_rise_cnt", (2*BITS)'(rise_q.size()), (2*BITS)'(N_RND));
    if (acc_q.size() == N_RND && out_q.size() == N_RND && rise_q.size() == N_RND) begin
      for (int i = 0; i < N_RND; i++) begin
        chk("rnd_dat", out_q[i].dat, ref_mul(acc_q[i].a, acc_q[i].b, acc_q[i].sqr));
        chk("rnd_tag", (2*BITS)'(out_q[i].tag), (2*BITS)'(acc_q[i].tag));
        chk("rnd_lat", (2*BITS)'(rise_q[i] - acc_q[i].cyc), (2*BITS)'(LAT));
        if (i > 0) begin
          chk("rnd_ii", (2*BITS)'((acc_q[i].cyc - acc_q[i-1].cyc) >= II), (2*BITS)'(1));
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
